// File: rtl/tx_pwm_burst_gen.sv
// tx_pwm_burst_gen: burst-framed PWM transmitter.
// A burst is one TRAIN symbol (carrying a rolling burst counter), NBURST DATA
// symbols fed through a valid/ready handshake, then NGAP silent GAP symbols.
// Each TRAIN/DATA symbol drives `out` high for TMIN + code*TUNIT ticks out of TSYM.
// Optional feature: define TX_PWM_PE_EN to build the pre-emphasis pulses on
// pe_lead/pe_trail; without it both outputs are constant 0.
// Every output is a flop loaded from the next-state values, so each output
// describes the same tick as the state registers in the same cycle.
module tx_pwm_burst_gen #(
    parameter int NBIT      = 4,
    parameter int TSYM      = 32,
    parameter int TMIN      = 4,
    parameter int TUNIT     = 1,
    parameter int NBURST    = 8,
    parameter int NGAP      = 4,
    parameter int TPE       = 2,
    parameter int IDLE_CODE = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic [NBIT-1:0] data,
    input  logic            data_valid,
    output logic            data_ready,
    output logic            out,
    output logic            pe_lead,
    output logic            pe_trail,
    output logic [NBIT-1:0] dtc_code,
    output logic            sym_strobe,
    output logic            gate,
    output logic            underflow
);

    localparam int TKW    = (TSYM > 1) ? $clog2(TSYM) : 1;
    localparam int SMAX   = (NBURST > NGAP) ? NBURST : NGAP;
    localparam int SCW    = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int HT_MAX = TMIN + (2**NBIT - 1) * TUNIT;

    localparam logic [TKW-1:0] TK_LAST   = TKW'(TSYM - 1);
    localparam logic [SCW-1:0] DATA_LAST = SCW'(NBURST - 1);
    localparam logic [SCW-1:0] GAP_LAST  = SCW'(NGAP - 1);

    // The longest pulse plus its trailing pre-emphasis must fit inside one
    // symbol, and code 0 must still produce a visible pulse.
    if (TMIN < 1 || HT_MAX + TPE >= TSYM) begin : g_bad_timing
        $error("tx_pwm_burst_gen: need TMIN >= 1 and TMIN+(2^NBIT-1)*TUNIT+TPE < TSYM");
    end
    if (NBURST < 1) begin : g_bad_burst
        $error("tx_pwm_burst_gen: NBURST must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAIN,
        S_DATA,
        S_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [TKW-1:0]  tk_q, tk_d;
    logic [SCW-1:0]  scnt_q, scnt_d;      // symbol index inside DATA or GAP
    logic [NBIT-1:0] bcnt_q, bcnt_d;      // burst counter sent in TRAIN
    logic [NBIT-1:0] code_q, code_d;      // code of the symbol at tk_d
    logic            uf_q, uf_d;
    logic            out_q, out_d;
    logic            gate_q, active_d;
    logic            strobe_q, strobe_d;
    logic            ready_q, ready_d;

    logic            boundary;
    logic            handshake;
    logic [31:0]     tk_ext;
    logic [31:0]     high_d;              // high time of the symbol at tk_d

    // Next-state logic: tick counter, symbol sequencing, code and flag capture.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        tk_d      = tk_q;
        scnt_d    = scnt_q;
        bcnt_d    = bcnt_q;
        code_d    = code_q;
        uf_d      = uf_q;
        boundary  = (state_q != S_IDLE) && (tk_q == TK_LAST);
        handshake = ready_q && data_valid;

        if (state_q == S_IDLE) begin
            if (en) begin
                state_d = S_TRAIN;
                tk_d    = '0;
                scnt_d  = '0;
                code_d  = bcnt_q;
                uf_d    = 1'b0;
            end
        end else if (!boundary) begin
            tk_d = tk_q + 1'b1;
        end else begin
            tk_d   = '0;
            scnt_d = '0;
            if (state_q == S_TRAIN) begin
                bcnt_d = bcnt_q + 1'b1;
            end
            unique case (state_q)
                S_TRAIN: state_d = S_DATA;
                S_DATA: begin
                    if (scnt_q == DATA_LAST) begin
                        state_d = (NGAP == 0) ? S_TRAIN : S_GAP;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (scnt_q == GAP_LAST) begin
                        state_d = S_TRAIN;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // The finished symbol always ran to completion; a low enable only
            // decides that nothing follows it. A word handshaked on this same
            // boundary is dropped along with the burst.
            if (!en) begin
                state_d = S_IDLE;
                scnt_d  = '0;
            end

            if (state_d == S_TRAIN) begin
                code_d = bcnt_q;
            end else if (state_d == S_DATA) begin
                if (handshake) begin
                    code_d = data;
                end else begin
                    code_d = NBIT'(IDLE_CODE);
                    uf_d   = 1'b1;
                end
            end
        end

        // Output values for the tick described by (state_d, tk_d).
        active_d = (state_d == S_TRAIN) || (state_d == S_DATA);
        tk_ext   = 32'(tk_d);
        high_d   = 32'(TMIN) + 32'(code_d) * 32'(TUNIT);
        out_d    = active_d && (tk_ext < high_d);
        strobe_d = active_d && (tk_d == '0);
        // Ready follows the burst structure: high on the last tick of a symbol
        // whose successor is a DATA symbol.
        ready_d  = (tk_d == TK_LAST) &&
                   ((state_d == S_TRAIN) ||
                    ((state_d == S_DATA) && (scnt_d != DATA_LAST)));
    end

    // State registers and registered outputs of the burst FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            tk_q     <= '0;
            scnt_q   <= '0;
            bcnt_q   <= '0;
            code_q   <= '0;
            uf_q     <= 1'b0;
            out_q    <= 1'b0;
            gate_q   <= 1'b0;
            strobe_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register loads from the
            // values computed before this edge, independent of statement order.
            state_q  <= state_d;
            tk_q     <= tk_d;
            scnt_q   <= scnt_d;
            bcnt_q   <= bcnt_d;
            code_q   <= code_d;
            uf_q     <= uf_d;
            out_q    <= out_d;
            gate_q   <= active_d;
            strobe_q <= strobe_d;
            ready_q  <= ready_d;
        end
    end

    assign out        = out_q;
    assign gate       = gate_q;
    assign sym_strobe = strobe_q;
    assign data_ready = ready_q;
    assign dtc_code   = code_q;
    assign underflow  = uf_q;

`ifdef TX_PWM_PE_EN
    logic        pe_lead_q, pe_lead_d;
    logic        pe_trail_q, pe_trail_d;
    logic [31:0] pe_len;

    // Pre-emphasis windows: leading pulse clipped to the high time, trailing
    // pulse of TPE ticks starting where out falls.
    always_comb begin
        pe_len     = (high_d < 32'(TPE)) ? high_d : 32'(TPE);
        pe_lead_d  = active_d && (tk_ext < pe_len);
        pe_trail_d = active_d && (tk_ext >= high_d) && (tk_ext < high_d + 32'(TPE));
    end

    // Pre-emphasis output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pe_lead_q  <= 1'b0;
            pe_trail_q <= 1'b0;
        end else begin
            pe_lead_q  <= pe_lead_d;
            pe_trail_q <= pe_trail_d;
        end
    end

    assign pe_lead  = pe_lead_q;
    assign pe_trail = pe_trail_q;
`else
    assign pe_lead  = 1'b0;
    assign pe_trail = 1'b0;
`endif

endmodule

// File: tb/tb_tx_pwm_burst_gen.sv
// tb_tx_pwm_burst_gen: directed scenarios plus randomized traffic for
// tx_pwm_burst_gen. Expected outputs come from a symbol-schedule model: the
// position in a burst is derived arithmetically from cycles since start.
module tb_tx_pwm_burst_gen;

    localparam int NBIT      = 4;
    localparam int TSYM      = 32;
    localparam int TMIN      = 4;
    localparam int TUNIT     = 1;
    localparam int NBURST    = 8;
    localparam int NGAP      = 4;
    localparam int TPE       = 2;
    localparam int IDLE_CODE = 0;
    localparam int PER       = 1 + NBURST + NGAP;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            en = 1'b0;
    logic [NBIT-1:0] data = '0;
    logic            data_valid = 1'b0;
    logic            data_ready;
    logic            out;
    logic            pe_lead;
    logic            pe_trail;
    logic [NBIT-1:0] dtc_code;
    logic            sym_strobe;
    logic            gate;
    logic            underflow;

    tx_pwm_burst_gen #(
        .NBIT(NBIT), .TSYM(TSYM), .TMIN(TMIN), .TUNIT(TUNIT),
        .NBURST(NBURST), .NGAP(NGAP), .TPE(TPE), .IDLE_CODE(IDLE_CODE)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .out(out), .pe_lead(pe_lead), .pe_trail(pe_trail),
        .dtc_code(dtc_code), .sym_strobe(sym_strobe), .gate(gate), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_run  = 1'b0;
    int m_cyc  = 0;   // cycles since the current session entered TRAIN
    int m_bcnt = 0;
    int m_code = 0;
    bit m_uf   = 1'b0;

    function automatic int m_tick();
        return m_cyc % TSYM;
    endfunction

    function automatic int m_pos();
        return (m_cyc / TSYM) % PER;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit dv, input logic [NBIT-1:0] d);
        int tick;
        int pos;
        if (!r) begin
            m_run = 1'b0; m_cyc = 0; m_bcnt = 0; m_code = 0; m_uf = 1'b0;
        end else if (!m_run) begin
            if (e) begin
                m_run = 1'b1; m_cyc = 0; m_uf = 1'b0; m_code = m_bcnt;
            end
        end else begin
            tick = m_tick();
            pos  = m_pos();
            if (tick != TSYM - 1) begin
                m_cyc++;
            end else begin
                if (pos == 0) m_bcnt = (m_bcnt + 1) % (1 << NBIT);
                if (!e) begin
                    m_run = 1'b0;
                end else begin
                    m_cyc++;
                    pos = m_pos();
                    if (pos == 0) begin
                        m_code = m_bcnt;
                    end else if (pos <= NBURST) begin
                        if (dv) m_code = int'(d);
                        else begin
                            m_code = IDLE_CODE;
                            m_uf   = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] m_expect();
        int tick, pos, ht;
        logic act, o, pl, pt, stb, rdy;
        logic [NBIT-1:0] c;
        tick = m_tick();
        pos  = m_pos();
        act  = m_run && (pos <= NBURST);
        ht   = TMIN + m_code * TUNIT;
        o    = act && (tick < ht);
        stb  = act && (tick == 0);
        rdy  = m_run && (tick == TSYM - 1) && (pos < NBURST);
`ifdef TX_PWM_PE_EN
        pl   = act && (tick < ((TPE < ht) ? TPE : ht));
        pt   = act && (tick >= ht) && (tick < ht + TPE);
`else
        pl   = 1'b0;
        pt   = 1'b0;
`endif
        c = m_code[NBIT-1:0];
        return 32'({m_uf, rdy, stb, act, pt, pl, o, c});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({underflow, data_ready, sym_strobe, gate, pe_trail, pe_lead, out, dtc_code});
    endfunction

    // ---------------- stimulus helpers ----------------
    int              feed_mode = 0;   // 0: test drives data, 1: always valid, 2: random
    logic [NBIT-1:0] src_q[$];

    task automatic cycle();
        bit e, dv, r, hs;
        logic [NBIT-1:0] d;
        if (feed_mode == 1) begin
            data_valid = 1'b1;
            data = (src_q.size() > 0) ? src_q[0] : NBIT'($urandom);
        end else if (feed_mode == 2) begin
            data_valid = ($urandom_range(0, 3) != 0);
            data = NBIT'($urandom);
        end
        e = en; dv = data_valid; r = rstn; d = data;
        hs = data_ready && data_valid;
        @(posedge clk);
        model_step(r, e, dv, d);
        if (hs && feed_mode == 1 && src_q.size() > 0) void'(src_q.pop_front());
        #1;
        check("outs", dut_vec(), m_expect());
    endtask

    task automatic run_sym(output logic [31:0] om, output logic [31:0] lm,
                           output logic [31:0] tm, output logic [31:0] sm);
        om = '0; lm = '0; tm = '0; sm = '0;
        for (int i = 0; i < TSYM; i++) begin
            cycle();
            om[i] = out; lm[i] = pe_lead; tm[i] = pe_trail; sm[i] = sym_strobe;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] om, lm, tm, sm;
    int          cnt, guard, rdy;

    initial begin
        // Reset with enable already high: everything must stay 0.
        feed_mode = 1;
        src_q = {4'd15, 4'd0, 4'd7};
        rstn = 1'b0;
        en   = 1'b1;
        repeat (3) cycle();
        check("rst_outs", dut_vec(), 32'h0);
        #2 rstn = 1'b1;

        // First TRAIN symbol: code 0, strobe at tick 0, 4 high ticks.
        run_sym(om, lm, tm, sm);
        check("train0_strobe", sm, 32'h1);
        check("train0_code", 32'(dtc_code), 32'h0);
        check("train0_out", om, 32'hF);
`ifdef TX_PWM_PE_EN
        check("pe_lead_code0", lm, 32'h3);
        check("pe_trail_code0", tm, 32'h30);
`else
        check("pe_lead_off", lm, 32'h0);
        check("pe_trail_off", tm, 32'h0);
`endif

        // Pulse widths for codes 15, 0, 7.
        run_sym(om, lm, tm, sm);
        check("pw_15", $countones(om), 19);
        check("pw_15_rise", 32'(om[0]), 32'h1);
        run_sym(om, lm, tm, sm);
        check("pw_0", $countones(om), 4);
        run_sym(om, lm, tm, sm);
        check("pw_7", $countones(om), 11);
        check("pw_7_code", 32'(dtc_code), 32'd7);

        // Rest of burst 0, then 16 more bursts: TRAIN code wraps 1..15,0.
        repeat (9 * TSYM) cycle();
        for (int b = 1; b <= 16; b++) begin
            run_sym(om, lm, tm, sm);
            check("train_code", 32'(dtc_code), 32'(b % 16));
            cnt = $countones(sm);
            repeat ((PER - 1) * TSYM) begin
                cycle();
                cnt += int'(sym_strobe);
            end
            check("burst_strobes", cnt, 9);
        end

        // Underflow: stop, restart, withhold data at the 3rd ready.
        en = 1'b0;
        repeat (TSYM + 1) cycle();
        check("idle_gate", 32'({gate, out}), 32'h0);
        feed_mode  = 0;
        data       = 4'd9;
        data_valid = 1'b1;
        en         = 1'b1;
        rdy   = 0;
        guard = 0;
        while (rdy < 3 && guard < 2000) begin
            cycle();
            guard++;
            if (data_ready) begin
                rdy++;
                if (rdy == 3) data_valid = 1'b0;
            end
        end
        check("uf_ready_seen", rdy, 3);
        run_sym(om, lm, tm, sm);
        data_valid = 1'b1;
        check("uf_high", $countones(om), 4);
        check("uf_code", 32'(dtc_code), 32'(IDLE_CODE));
        check("uf_flag", 32'(underflow), 32'h1);
        feed_mode = 1;
        repeat (200) cycle();
        check("uf_sticky", 32'(underflow), 32'h1);
        en = 1'b0;
        repeat (TSYM + 1) cycle();
        check("uf_idle_hold", 32'(underflow), 32'h1);
        en = 1'b1;
        cycle();
        check("uf_clear", 32'(underflow), 32'h0);

        // Enable dropped at tick 10 of a DATA symbol.
        guard = 0;
        while (!(m_run && m_pos() >= 1 && m_pos() <= NBURST && m_tick() == 10) && guard < 1000) begin
            cycle();
            guard++;
        end
        check("en_drop_reached", 32'(guard < 1000), 32'h1);
        en  = 1'b0;
        cnt = 0;
        repeat (TSYM - 1 - 10) begin
            cycle();
            cnt += int'(gate);
        end
        check("en_drop_complete", cnt, TSYM - 1 - 10);
        cycle();
        check("en_drop_idle", 32'({gate, out, sym_strobe}), 32'h0);
        repeat (10) cycle();
        check("en_drop_stay", 32'({gate, out}), 32'h0);

        // Reset asserted at tick 2 while out is high.
        en = 1'b1;
        guard = 0;
        while (!(m_run && m_tick() == 2) && guard < 1000) begin
            cycle();
            guard++;
        end
        check("pre_rst_out", 32'(out), 32'h1);
        #2 rstn = 1'b0;
        #1;
        check("rst_async_out", 32'(out), 32'h0);
        check("rst_async_all", dut_vec(), 32'h0);
        repeat (3) cycle();
        rstn = 1'b1;

        // Randomized traffic with occasional enable toggles.
        feed_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_pwm_burst_gen.md
TX_PWM_BURST_GEN -- requirements
Module: tx_pwm_burst_gen

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide NBIT, 4, bits per PWM symbol, which sets the width of the DTC code.
REQ-002 SHALL provide TSYM, 32, clk cycles per symbol.
REQ-003 SHALL provide TMIN, 4, minimum high time in cycles, corresponding to code 0.
REQ-004 SHALL provide TUNIT, 1, cycles of high time per code LSB.
REQ-005 SHALL provide NBURST, 8, data symbols per burst.
REQ-006 SHALL provide NGAP, 4, idle symbols between bursts.
REQ-007 SHALL provide TPE, 2, pre-emphasis pulse length in cycles.
REQ-008 SHALL provide IDLE_CODE, 0, code sent when a data symbol underflows.

Ports (name, direction, width, meaning):
REQ-009 SHALL have clk, input, 1, the single clock; all logic is on posedge clk.
REQ-010 SHALL have rstn, input, 1, asynchronous active-low reset.
REQ-011 SHALL have en, input, 1, burst enable.
REQ-012 SHALL have data, input, NBIT, symbol code.
REQ-013 SHALL have data_valid, input, 1, data is offered.
REQ-014 SHALL have data_ready, output, 1, data is accepted on valid&ready.
REQ-015 SHALL have out, output, 1, PWM line.
REQ-016 SHALL have pe_lead / pe_trail, output, 1 each, pre-emphasis edge pulses.
REQ-017 SHALL have dtc_code, output, NBIT, code of the current symbol.
REQ-018 SHALL have sym_strobe, output, 1, high at tick 0 of each transmitted symbol.
REQ-019 SHALL have gate, output, 1, high during TRAIN and DATA symbols.
REQ-020 SHALL have underflow, output, 1, sticky flag.

Function
REQ-021 The tick counter tk SHALL run 0..TSYM-1 and wrap every symbol while state!=IDLE.
REQ-022 The FSM states SHALL be IDLE, TRAIN, DATA and GAP.
REQ-023 The FSM SHALL move from IDLE to TRAIN on the cycle after en is sampled high, with tk=0.
REQ-024 TRAIN SHALL last one symbol, with code = burst counter bcnt (NBIT bits); bcnt SHALL increment modulo 2^NBIT at the end of each TRAIN symbol.
REQ-025 TRAIN SHALL be followed by DATA for NBURST symbols, then GAP for NGAP symbols, then TRAIN again.
REQ-026 State changes SHALL occur only at symbol boundaries (tk==TSYM-1).
REQ-027 If en is low at a boundary, the next state SHALL be IDLE; the current symbol always completes.
REQ-028 During TRAIN and DATA, out SHALL be 1 for tk < TMIN+code*TUNIT and 0 otherwise.
REQ-029 out SHALL be 0 in GAP and IDLE.
REQ-030 Elaboration SHALL fail unless TMIN+(2^NBIT-1)*TUNIT+TPE < TSYM and TMIN >= 1.
REQ-031 data_ready SHALL be high only at tk==TSYM-1 when the next symbol is DATA.
REQ-032 A word accepted there SHALL be transmitted in the next symbol, so latency from acceptance to the rise of out is 1 cycle.
REQ-033 If data_valid is low while data_ready is high, the next DATA symbol SHALL use IDLE_CODE and underflow SHALL set.
REQ-034 underflow SHALL clear only by reset or on an IDLE to TRAIN transition.
REQ-035 dtc_code SHALL update at tk==0 of every TRAIN/DATA symbol and hold otherwise.
REQ-036 sym_strobe SHALL be high for 1 cycle at tk==0 of each TRAIN/DATA symbol.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 On rstn low, the block SHALL asynchronously set state=IDLE, tk=0, bcnt=0, out=0, pe_lead=0, pe_trail=0, dtc_code=0, sym_strobe=0, gate=0, data_ready=0 and underflow=0.
REQ-039 Reset asserted mid-symbol SHALL immediately force out=0 and discard the symbol.
REQ-040 After rstn rises, the block SHALL remain in IDLE until en is sampled high.

Configuration
REQ-041 With TX_PWM_PE_EN defined, pe_lead SHALL be high for min(TPE, high time) cycles starting at the rising edge of out.
REQ-042 With TX_PWM_PE_EN defined, pe_trail SHALL be high for TPE cycles starting at the falling edge of out.
REQ-043 Without TX_PWM_PE_EN, pe_lead and pe_trail SHALL be tied 0 and no pre-emphasis logic SHALL be present.

Verification
REQ-044 Reset test: rstn low with en=1 -> all outputs 0; after release, one cycle with en=1 -> sym_strobe high, first TRAIN symbol with code 0, out high for 4 cycles.
REQ-045 Burst sequence test: en held high, data always valid -> per burst 1 TRAIN + 8 DATA + 4 GAP symbols = 416 cycles; TRAIN codes 0,1,...,15,0 wrap across 17 bursts.
REQ-046 Pulse-width test: data=15, then 0, then 7 -> out high times 19, 4 and 11 cycles in consecutive 32-cycle symbols.
REQ-047 Underflow test: data_valid low at the 3rd data_ready -> that symbol has a high time of 4 cycles and underflow=1; underflow stays 1 until en is dropped and reasserted.
REQ-048 Enable and mid-symbol reset test: en dropped at tk=10 of a DATA symbol -> symbol completes and the block enters IDLE with out=0; a separate run with rstn low at tk=2 -> out=0 within the same cycle.
REQ-049 Pre-emphasis test (TX_PWM_PE_EN defined): code 0 -> pe_lead high for 2 cycles at ticks 0-1 and pe_trail high at ticks 4-5; undefined -> both stay 0.
